// File: rtl/gray_to_bin_pipe_if.sv
// Valid/ready bus for the Gray-to-binary decoder: input stream, output stream
// and step-violation counter access.
interface gray_to_bin_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_gray;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bin;
  logic             out_err;
  logic             err_clr;
  logic [7:0]       err_cnt;

  modport master (
    output in_valid, in_gray, out_ready, err_clr,
    input  in_ready, out_valid, out_bin, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_gray, out_ready, err_clr,
    output in_ready, out_valid, out_bin, out_err, err_cnt
  );
endinterface

// File: rtl/gray_to_bin_pipe.sv
// Elastic pipelined Gray-to-binary decoder, MSB slice resolved first.
// Optional Gray step checker enabled by macro GTOB_STEP_CHECK_EN.
module gray_to_bin_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  gray_to_bin_pipe_if.slave  bus
);
  localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

  // Each word carries resolved binary bits above the current slice and raw
  // Gray bits below it, so one register per stage is enough.
  function automatic logic [WIDTH-1:0] resolve(input logic [WIDTH-1:0] w, input int s);
    logic [WIDTH-1:0] r;
    r = w;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (i <= WIDTH - 1 - s * CHUNK && i >= WIDTH - (s + 1) * CHUNK)
        r[i] = r[i+1] ^ r[i];
    end
    return r;
  endfunction

  logic [STAGES-1:0]            r_vld_pipe;
  logic [STAGES-1:0][WIDTH-1:0] r_data;
  logic [STAGES-1:0]            r_err;

  logic [STAGES-1:0]            w_en;
  logic [STAGES-1:0]            w_vin;
  logic [STAGES-1:0][WIDTH-1:0] w_din;
  logic [STAGES-1:0]            w_ein;
  logic                         w_acc;
  logic                         w_step_err;

  always_comb begin
    w_en = '0;
    w_en[STAGES-1] = !r_vld_pipe[STAGES-1] | bus.out_ready;
    for (int s = STAGES - 2; s >= 0; s--)
      w_en[s] = !r_vld_pipe[s] | w_en[s+1];
  end

  always_comb begin
    w_vin = '0;
    w_din = '0;
    w_ein = '0;
    w_vin[0] = bus.in_valid;
    w_din[0] = bus.in_gray;
    w_ein[0] = w_step_err;
    for (int s = 1; s < STAGES; s++) begin
      w_vin[s] = r_vld_pipe[s-1];
      w_din[s] = r_data[s-1];
      w_ein[s] = r_err[s-1];
    end
  end

  assign w_acc        = bus.in_valid & w_en[0];
  assign bus.in_ready = w_en[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_data     <= '0;
      r_err      <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (w_en[s]) begin
          r_vld_pipe[s] <= w_vin[s];
          r_data[s]     <= resolve(w_din[s], s);
          r_err[s]      <= w_ein[s];
        end
      end
    end
  end

  assign bus.out_valid = r_vld_pipe[STAGES-1];
  assign bus.out_bin   = r_data[STAGES-1];
  assign bus.out_err   = r_err[STAGES-1];

`ifdef GTOB_STEP_CHECK_EN
  logic [WIDTH-1:0] r_hist;
  logic             r_hist_vld;
  logic [7:0]       r_err_cnt;

  assign w_step_err = r_hist_vld && ($countones(bus.in_gray ^ r_hist) > 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist     <= '0;
      r_hist_vld <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (w_acc) begin
        r_hist     <= bus.in_gray;
        r_hist_vld <= 1'b1;
      end
      // Clear wins over a same-cycle increment.
      if (bus.err_clr)
        r_err_cnt <= '0;
      else if (w_acc && w_step_err && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  logic w_unused;
  assign w_unused    = bus.err_clr & w_acc;
  assign w_step_err  = 1'b0;
  assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_gray_to_bin_pipe.sv
// Scoreboard bench for gray_to_bin_pipe: randomized and directed streams
// against a prefix-XOR reference model with step-check bookkeeping.
module tb_gray_to_bin_pipe;
  localparam int W = 4;
  localparam int S = 2;
`ifdef GTOB_STEP_CHECK_EN
  localparam bit STEP = 1'b1;
`else
  localparam bit STEP = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] bin;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_to_bin_pipe_if #(.WIDTH(W)) bus ();

  gray_to_bin_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t         q[$];
  int           checks = 0;
  int           fails  = 0;
  logic [W-1:0] hist;
  logic         hist_vld = 1'b0;
  logic [7:0]   exp_cnt  = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  // One cycle of stimulus; returns whether the word was accepted.
  task automatic cyc(input logic v, input logic [W-1:0] g, input logic ordy,
                     input logic clr, output logic acc);
    exp_t       e;
    logic       flag;
    logic [7:0] nxt;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_gray   = g;
    bus.out_ready = ordy;
    bus.err_clr   = clr;
    #1;
    acc  = v && bus.in_ready;
    flag = 1'b0;
    if (acc) begin
      flag  = STEP && hist_vld && ($countones(g ^ hist) > 1);
      e.bin = g2b(g);
      e.err = flag;
      q.push_back(e);
      hist     = g;
      hist_vld = 1'b1;
    end
    nxt = exp_cnt;
    if (STEP) begin
      if (clr) nxt = 8'd0;
      else if (flag && nxt != 8'hFF) nxt = nxt + 8'd1;
    end
    @(posedge clk);
    exp_cnt = nxt;
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      cyc(1'b0, '0, 1'b1, 1'b0, acc);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
  endtask

  // Monitor: pops expected words, checks counter and output hold while stalled.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_bin;
  logic         prev_err;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("err_cnt", bus.err_cnt, exp_cnt);
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_bin", bus.out_bin, prev_bin);
        chk("hold_err", bus.out_err, prev_err);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", bus.out_bin, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("out_bin", bus.out_bin, e.bin);
          chk("out_err", bus.out_err, e.err);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_bin   = bus.out_bin;
      prev_err   = bus.out_err;
    end
  end

  initial begin
    logic         acc;
    logic [W-1:0] g;
    logic [W-1:0] m;
    int           idx;
    int           n;

    bus.in_valid  = 1'b0;
    bus.in_gray   = '0;
    bus.out_ready = 1'b1;
    bus.err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_bin", bus.out_bin, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Latency: visible one edge after the acceptance edge with two stages
    cyc(1'b1, 4'b0110, 1'b1, 1'b0, acc);
    chk("lat_accept", acc, 1);
    #1;
    chk("lat_not_yet", bus.out_valid, 0);
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    #1;
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_bin", bus.out_bin, 4'b0100);
    cyc(1'b1, 4'b1000, 1'b1, 1'b0, acc);
    cyc(1'b1, 4'b1111, 1'b1, 1'b0, acc);
    drain();

    // Full-rate Gray count
    for (int i = 0; i < 16; i++) begin
      g = W'(i ^ (i >> 1));
      cyc(1'b1, g, 1'b1, 1'b0, acc);
      chk("stream_accept", acc, 1);
      if (i >= 1) begin
        #1;
        chk("stream_out_valid", bus.out_valid, 1);
      end
    end
    drain();

    // Backpressure: two words fill the pipe, then in_ready must drop
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      g = W'(idx ^ (idx >> 1));
      cyc(1'b1, g, 1'b0, 1'b0, acc);
      chk("bp_in_ready", acc, (k < 2) ? 1 : 0);
      if (acc) idx++;
    end
    n = 0;
    while (idx < 10 && n < 40) begin
      g = W'(idx ^ (idx >> 1));
      cyc(1'b1, g, 1'b1, 1'b0, acc);
      if (acc) idx++;
      n++;
    end
    chk("bp_release_done", idx, 10);
    drain();

    // Step checking: violation, repeat, clear colliding with a violation
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, acc);
    cyc(1'b1, 4'b0011, 1'b1, 1'b0, acc);
    cyc(1'b1, 4'b0011, 1'b1, 1'b0, acc);
    cyc(1'b1, 4'b1100, 1'b1, 1'b1, acc);
    drain();

    // Saturation
    for (int i = 0; i < 300; i++)
      cyc(1'b1, (i % 2) ? 4'b1111 : 4'b0000, 1'b1, 1'b0, acc);
    drain();
    chk("err_cnt_sat", bus.err_cnt, STEP ? 255 : 0);

    // Randomized traffic with random stalls and clears
    g = '0;
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 9);
      if (n < 7) begin
        m = '0;
        m[$urandom_range(0, W-1)] = 1'b1;
        g = hist ^ m;
      end else if (n < 8) begin
        g = hist;
      end else begin
        g = W'($urandom);
      end
      cyc($urandom_range(0, 3) != 0, g, $urandom_range(0, 3) != 0,
          $urandom_range(0, 19) == 0, acc);
    end
    drain();

    // Reset with two words in flight
    cyc(1'b1, 4'b1100, 1'b0, 1'b0, acc);
    cyc(1'b1, 4'b1100, 1'b0, 1'b0, acc);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_err_cnt", bus.err_cnt, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    q.delete();
    hist_vld = 1'b0;
    exp_cnt  = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, acc);
    cyc(1'b1, 4'b0011, 1'b1, 1'b0, acc);
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    #1;
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_bin", bus.out_bin, 4'b0010);
    chk("post_rst_err", bus.out_err, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
